// File: rtl/note_keypad_pkg.sv
// Shared definitions for the piano keypad front end: note codes and
// helpers that turn a debounced key vector into a count and a note code.
package note_keypad_pkg;

    localparam int NUM_KEYS = 8;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    // Key index i (0 = C4 ... 7 = C5) maps to note code i+1.
    function automatic logic [3:0] key_to_code(input int idx);
        return 4'(idx + 1);
    endfunction

    // Number of keys currently down.
    function automatic logic [3:0] key_count(input logic [NUM_KEYS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++)
            n = n + {3'd0, v[i]};
        return n;
    endfunction

    // Code of the lowest key down; only meaningful when exactly one is set.
    function automatic logic [3:0] key_code(input logic [NUM_KEYS-1:0] v);
        logic [3:0] c;
        c = NOTE_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (v[i]) c = key_to_code(i);
        return c;
    endfunction

endpackage

// File: rtl/note_keypad_if.sv
// Keypad-side bundle: raw buttons in, note code / strobe / chord flag out.
interface note_keypad_if;
    import note_keypad_pkg::*;

    logic [NUM_KEYS-1:0] keys;
    logic [3:0]          note;
    logic                note_strobe;
    logic                key_err;

    modport master (output keys, input note, note_strobe, key_err);
    modport slave  (input keys, output note, note_strobe, key_err);
endinterface

// File: rtl/note_keypad_debounce.sv
// One key: two-flop synchroniser followed by a saturating debounce counter.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic CLK,
    input  logic RESET,
    input  logic key_in,
    output logic stable
);
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Synchronise, then flip stable only after DEBOUNCE_CYCLES straight
    // cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync   <= 2'b00;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], key_in};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/note_keypad.sv
// Keypad front end: debounce eight buttons and encode them into a note
// code, forcing a none gap between distinct presses and rejecting chords.
module note_keypad
    import note_keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic          CLK,
    input  logic          RESET,
    note_keypad_if.slave  kp
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HELD  = 2'd1;
    localparam logic [1:0] S_MULTI = 2'd2;

    logic [NUM_KEYS-1:0] stable;
    logic [3:0]          n_down;
    logic [3:0]          code;
    logic [1:0]          state;
    logic [3:0]          note_r;
    logic                strobe_r;
    logic                err_r;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .CLK    (CLK),
            .RESET  (RESET),
            .key_in (kp.keys[i]),
            .stable (stable[i])
        );
    end

    assign n_down = key_count(stable);
    assign code   = key_code(stable);

    // Encoder FSM; a swap to a different single key goes through IDLE so
    // note shows none for one cycle before the new code.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= S_IDLE;
            note_r   <= NOTE_NONE;
            strobe_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    note_r <= NOTE_NONE;
                    err_r  <= 1'b0;
                    if (n_down == 4'd1) begin
                        state    <= S_HELD;
                        note_r   <= code;
                        strobe_r <= 1'b1;
                    end else if (n_down > 4'd1) begin
                        state <= S_MULTI;
                        err_r <= 1'b1;
                    end
                end
                S_HELD: begin
                    if (n_down > 4'd1) begin
                        state  <= S_MULTI;
                        note_r <= NOTE_NONE;
                        err_r  <= 1'b1;
                    end else if (n_down == 4'd0 || code != note_r) begin
                        state  <= S_IDLE;
                        note_r <= NOTE_NONE;
                    end
                end
                S_MULTI: begin
                    note_r <= NOTE_NONE;
                    if (n_down == 4'd0) begin
                        state <= S_IDLE;
                        err_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    note_r <= NOTE_NONE;
                    err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign kp.note        = note_r;
    assign kp.note_strobe = strobe_r;
    assign kp.key_err     = err_r;
endmodule
